riscv_div_unit: RTL and testbench
=================================

# riscv_div_unit

Multi-cycle iterative restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. Computes one quotient bit per cycle by shift-and-subtract and returns the result after a fixed latency. Sits in the execute stage beside the ALU adder; the pipeline stalls on `busy` and resumes on `done`.

## Interface
- `XLEN`, 32, operand and result width in bits
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  launch request; sampled only in IDLE or DONE
- `flush`  in  1  abort the in-flight operation (pipeline kill)
- `op`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- `dividend`  in  XLEN  rs1 operand, sampled with `start`
- `divisor`  in  XLEN  rs2 operand, sampled with `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  single-cycle pulse; `result` valid
- `result`  out  XLEN  quotient or remainder; held until next accepted `start`

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + `start` (and not `flush`): latch `op`; convert operands to unsigned magnitudes (signed ops only); record quotient sign = sign(dividend) xor sign(divisor) and remainder sign = sign(dividend); clear the partial remainder (XLEN+1 bits) and load the quotient register with the dividend magnitude; set count = XLEN; go to CALC.
- CALC: shift {rem, quo} left 1; trial = rem - divisor magnitude; if trial is non-negative, rem = trial and quo LSB = 1, otherwise quo LSB = 0; decrement count; go to FIX after the XLEN-th step.
- FIX: apply two's-complement sign correction; select quotient (DIV/DIVU) or remainder (REM/REMU); register into `result`; go to DONE.
- DONE: `done` = 1 for one cycle; go to IDLE, or re-launch if `start` is high.
- Magnitude of 0x8000_0000 is treated as unsigned 2^31 and does not overflow.
- Divide by zero: quotient = all ones (every op), remainder = dividend unchanged. Forced in FIX, with no sign correction.
- Signed overflow (0x8000_0000 / 0xFFFF_FFFF, DIV/REM): quotient = 0x8000_0000, remainder = 0.
- `start` while in CALC or FIX: ignored. No queueing.
- `flush` in any state: next state is IDLE, no `done`, `result` unchanged. If `flush` and `start` are high together, `flush` wins.

## Timing
- Reset values: `busy` = 0, `done` = 0, `result` = 0, state = IDLE, internal registers = 0.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous); no `done` is issued.
- `start` sampled at edge 0: CALC occupies cycles 1..XLEN, FIX is cycle XLEN+1, `done` is high in cycle XLEN+2. That is 34 cycles for XLEN = 32.
- `busy` rises the cycle after `start` and falls the cycle after `done`, unless a back-to-back `start` is accepted in DONE.
- `result` changes only on the FIX→DONE edge.

## Configuration
- `DIV_EARLY_OUT_EN` defined: divide-by-zero and signed-overflow cases are detected at launch and skip CALC (IDLE → FIX → DONE). `done` arrives in cycle 2.
- Not defined: every op runs the full XLEN+2 cycles. Results are bit-identical in both builds.

## Structure
- Package `riscv_div_pkg`: `div_op_t` enum (DIV, DIVU, REM, REMU); `div_state_t` enum (IDLE, CALC, FIX, DONE); `DIV_OP_W` = 2.
- One sub-module, `div_step`: combinational single restoring step (shift, trial subtract, select); instantiated once in the CALC datapath.
- Counter width is $clog2(XLEN)+1.

## Test plan
- DIVU 100 / 7 → `result` = 14, `done` in cycle 34; REMU with the same operands → 2.
- DIV 0xFFFF_FFF9 (−7) / 2 → 0xFFFF_FFFD (−3); REM with the same operands → 0xFFFF_FFFF (−1).
- DIV 5 / 0 → 0xFFFF_FFFF; REMU 5 / 0 → 5; `done` in cycle 2 with `DIV_EARLY_OUT_EN`, cycle 34 without.
- DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; REM with the same operands → 0.
- Launch DIVU, pulse `start` with new operands at cycle 10, then `flush` at cycle 20 → no `done`, `busy` low at cycle 21, `result` keeps its previous value.
- Drop `rst_n` at cycle 15 of an operation → `busy`/`done`/`result` = 0 immediately; a new DIVU 9 / 3 after release → 3.

Source files
------------

// File: rtl/riscv_div_pkg.sv
// riscv_div_pkg: shared types for the RV32M iterative divider
package riscv_div_pkg;

    localparam int DIV_OP_W = 2;

    typedef enum logic [DIV_OP_W-1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_t;

endpackage

// File: rtl/riscv_div_unit_div_step.sv
// div_step: one combinational restoring-division step (shift, trial subtract, select)
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN+1:0] sh;
    logic [XLEN+1:0] trial;

    // One extra guard bit keeps the sign of the trial difference unambiguous
    assign sh    = {rem_i, quo_i[XLEN-1]};
    assign trial = sh - {2'b00, dvs_i};
    assign rem_o = trial[XLEN+1] ? sh[XLEN:0] : trial[XLEN:0];
    assign quo_o = {quo_i[XLEN-2:0], ~trial[XLEN+1]};

endmodule

// File: rtl/riscv_div_unit.sv
// riscv_div_unit: multi-cycle restoring divider for DIV/DIVU/REM/REMU.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC.
module riscv_div_unit
    import riscv_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                flush_i,
    input  logic [DIV_OP_W-1:0] op_i,
    input  logic [XLEN-1:0]     dividend_i,
    input  logic [XLEN-1:0]     divisor_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [XLEN-1:0]     result_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state_q, state_d;
    div_op_t         op_q, op_d;
    logic            quo_neg_q, quo_neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            launch, sgn, dvd_neg, dvs_neg, is_rem;
    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo, q_fix, r_fix;

    assign launch  = (state_q == IDLE || state_q == DONE) && start_i && !flush_i;
    assign sgn     = ~op_i[0];
    assign dvd_neg = sgn & dividend_i[XLEN-1];
    assign dvs_neg = sgn & divisor_i[XLEN-1];
    assign is_rem  = (op_q == REM) || (op_q == REMU);
    assign q_fix   = quo_neg_q ? -quo_q : quo_q;
    assign r_fix   = rem_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Next-state and datapath: flush dominates, then launch, then per-state work
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        dvd_d     = dvd_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        if (flush_i) begin
            state_d = IDLE;
        end else if (launch) begin
            op_d      = div_op_t'(op_i);
            quo_neg_d = dvd_neg ^ dvs_neg;
            rem_neg_d = dvd_neg;
            div0_d    = (divisor_i == '0);
            ovf_d     = sgn && (dividend_i == MIN_NEG) && (&divisor_i);
            rem_d     = '0;
            quo_d     = dvd_neg ? -dividend_i : dividend_i;
            dvs_d     = dvs_neg ? -divisor_i : divisor_i;
            dvd_d     = dividend_i;
            cnt_d     = CW'(XLEN);
`ifdef DIV_EARLY_OUT_EN
            state_d   = (div0_d || ovf_d) ? FIX : CALC;
`else
            state_d   = CALC;
`endif
        end else if (state_q == CALC) begin
            rem_d   = step_rem;
            quo_d   = step_quo;
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == CW'(1)) ? FIX : CALC;
        end else if (state_q == FIX) begin
            result_d = div0_q ? (is_rem ? dvd_q : '1) :
                       ovf_q  ? (is_rem ? '0 : MIN_NEG) :
                       (is_rem ? r_fix : q_fix);
            state_d  = DONE;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= DIV;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            dvd_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            dvd_q     <= dvd_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_riscv_div_unit.sv
// tb_riscv_div_unit: randomized and directed checks of riscv_div_unit against an arithmetic model
module tb_riscv_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks = 0;
    int failures = 0;

    riscv_div_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .flush_i    (flush_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    // RISC-V M semantics from plain arithmetic; 64-bit signed math covers the overflow case
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
`endif
        return 34;
    endfunction

    // Called at a negedge: launch, then count cycles until done (start edge = cycle 0)
    task automatic go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] res, output int lat, output logic busy1);
        op_i = op; dividend_i = a; divisor_i = b; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        busy1 = busy_o;
        lat = 1;
        while (!done_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = result_o;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        logic b1;
        @(negedge clk);
        go(op, a, b, res, lat, b1);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_async busy=%b done=%b result=%h required 0/0/0", busy_o, done_o, result_o);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_idle busy=%b done=%b result=%h required 0/0/0", busy_o, done_o, result_o);
        end
    endtask

    task automatic test_directed;
        logic [1:0]  ops [8] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10};
        logic [31:0] as  [8] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [8] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] req [8] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat);
            checks++;
            if (res !== req[i]) begin
                failures++;
                $display("FAIL directed_result[%0d] got=%h required=%h", i, res, req[i]);
            end
            checks++;
            if (lat !== exp_lat(ops[i], as[i], bs[i])) begin
                failures++;
                $display("FAIL directed_latency[%0d] got=%0d required=%0d", i, lat, exp_lat(ops[i], as[i], bs[i]));
            end
            @(negedge clk);
            checks++;
            if (busy_o !== 1'b0 || done_o !== 1'b0) begin
                failures++;
                $display("FAIL directed_idle_after[%0d] busy=%b done=%b required 0/0", i, busy_o, done_o);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, res;
        logic [1:0]  op;
        int lat;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            run_op(op, a, b, res, lat);
            checks++;
            if (res !== model(op, a, b) || lat !== exp_lat(op, a, b)) begin
                failures++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h lat=%0d required=%h lat=%0d",
                         i, op, a, b, res, lat, model(op, a, b), exp_lat(op, a, b));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] res;
        int lat;
        logic b1;
        run_op(2'b01, 32'd1000, 32'd9, res, lat);
        go(2'b10, 32'hFFFF_FF00, 32'd7, res, lat, b1);
        checks++;
        if (b1 !== 1'b1 || res !== model(2'b10, 32'hFFFF_FF00, 32'd7) || lat !== 34) begin
            failures++;
            $display("FAIL back_to_back busy1=%b got=%h lat=%0d required busy1=1 %h lat=34",
                     b1, res, lat, model(2'b10, 32'hFFFF_FF00, 32'd7));
        end
    endtask

    task automatic test_start_ignored;
        logic [31:0] res;
        int lat;
        logic b1;
        @(negedge clk);
        op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        lat = 1;
        while (!done_o && lat < 200) begin
            if (lat == 10) begin op_i = 2'b00; dividend_i = 32'd1000; divisor_i = 32'd3; start_i = 1'b1; end
            if (lat == 11) start_i = 1'b0;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (result_o !== 32'd14 || lat !== 34) begin
            failures++;
            $display("FAIL start_ignored got=%h lat=%0d required=0000000e lat=34", result_o, lat);
        end
        b1 = 1'b0;
        res = '0;
    endtask

    task automatic test_flush;
        logic [31:0] prev;
        int lat, cyc;
        logic seen;
        run_op(2'b01, 32'd100, 32'd7, prev, lat);
        @(negedge clk);
        op_i = 2'b01; dividend_i = 32'hFFFF_0000; divisor_i = 32'd3; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1;
        seen = 1'b0;
        while (cyc < 21) begin
            if (cyc == 10) begin dividend_i = 32'd77; divisor_i = 32'd5; start_i = 1'b1; end
            if (cyc == 11) start_i = 1'b0;
            if (cyc == 20) flush_i = 1'b1;
            @(negedge clk);
            cyc++;
            seen |= done_o;
        end
        flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy cycle21 busy=%b required 0", busy_o);
        end
        repeat (40) begin
            @(negedge clk);
            seen |= done_o;
        end
        checks++;
        if (seen !== 1'b0 || result_o !== 32'd14) begin
            failures++;
            $display("FAIL flush_no_done done_seen=%b result=%h required 0 0000000e", seen, result_o);
        end
        op_i = 2'b00; dividend_i = 32'd50; divisor_i = 32'd5; start_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_beats_start busy=%b required 0", busy_o);
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] res;
        int lat;
        run_op(2'b01, 32'd100, 32'd7, res, lat);
        @(negedge clk);
        op_i = 2'b01; dividend_i = $urandom; divisor_i = 32'd13; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
            failures++;
            $display("FAIL async_reset busy=%b done=%b result=%h required 0/0/0", busy_o, done_o, result_o);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_hold busy=%b done=%b required 0/0", busy_o, done_o);
        end
        rst_n = 1'b1;
        run_op(2'b01, 32'd9, 32'd3, res, lat);
        checks++;
        if (res !== 32'd3 || lat !== 34) begin
            failures++;
            $display("FAIL after_reset got=%h lat=%0d required=00000003 lat=34", res, lat);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_start_ignored;
        test_flush;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
